// File: rtl/coproc_pkg.sv
// Shared types and default geometry for the image coprocessor pipeline stages.
package coproc_pkg;

   localparam int PIX_W = 12;
   localparam int IMG_W = 256;
   localparam int IMG_H = 256;
   localparam int ACC_W = 17;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      MODE_BLUR    = 2'd0,
      MODE_SHARPEN = 2'd1,
      MODE_EDGE    = 2'd2,
      MODE_PASS    = 2'd3
   } conv_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } eng_state_e;

endpackage

// File: rtl/conv3x3_kernel.sv
// Combinational per-mode kernel sum built from the registered row partials.
// o_sumB is only non-zero for EDGE, where it carries the vertical Sobel term.
module conv3x3_kernel import coproc_pkg::*; (
   input  logic [1:0]              i_mode,
   input  logic signed [ACC_W-1:0] i_wTop,
   input  logic signed [ACC_W-1:0] i_wMid,
   input  logic signed [ACC_W-1:0] i_wBot,
   input  logic signed [ACC_W-1:0] i_dTop,
   input  logic signed [ACC_W-1:0] i_dMid,
   input  logic signed [ACC_W-1:0] i_dBot,
   input  logic signed [ACC_W-1:0] i_cTop,
   input  logic signed [ACC_W-1:0] i_cMid,
   input  logic signed [ACC_W-1:0] i_cBot,
   input  logic signed [ACC_W-1:0] i_lrMid,
   output logic signed [ACC_W-1:0] o_sumA,
   output logic signed [ACC_W-1:0] o_sumB
);

   always_comb begin
      o_sumA = '0;
      o_sumB = '0;
      case (conv_mode_e'(i_mode))
         MODE_BLUR:    o_sumA = i_wTop + (i_wMid <<< 1) + i_wBot;
         MODE_SHARPEN: o_sumA = (i_cMid <<< 2) + i_cMid - (i_cTop + i_cBot + i_lrMid);
         MODE_EDGE: begin
            o_sumA = i_dTop + (i_dMid <<< 1) + i_dBot;
            o_sumB = i_wBot - i_wTop;
         end
         default:      o_sumA = i_cMid;
      endcase
   end

endmodule

// File: rtl/conv3x3_engine.sv
// Three-stage 3x3 convolution engine: S1 row partials, S2 kernel sum, S3 saturate into output regs.
// Optional CONV_BORDER_ZERO_EN forces frame-border pixels to zero in every mode except PASS.
module conv3x3_engine #(
   parameter int PIX_W = 12,
   parameter int IMG_W = 256,
   parameter int IMG_H = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   output logic               busy,
   output logic               done,
   input  logic [3*PIX_W-1:0] win_top,
   input  logic [3*PIX_W-1:0] win_mid,
   input  logic [3*PIX_W-1:0] win_bot,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [PIX_W-1:0]   pix_out,
   output logic [7:0]         out_col,
   output logic [7:0]         out_row,
   output logic               out_last,
   output logic               out_valid,
   input  logic               out_ready
);
   import coproc_pkg::*;

   localparam logic [7:0] LAST_COL = 8'(IMG_W - 1);
   localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);
   localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

   function automatic logic signed [ACC_W-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({{(ACC_W-PIX_W){1'b0}}, p});
   endfunction

   eng_state_e r_state, w_stateNext;
   conv_mode_e r_modeQ;
   logic       r_done, r_inDone, r_v1, r_v2, r_outValid, r_outLast;
   logic [7:0] r_inCol, r_inRow, r_col1, r_row1, r_col2, r_row2, r_outCol, r_outRow;
   logic [PIX_W-1:0] r_pix, w_pix;
   logic signed [ACC_W-1:0] r_wTop, r_wMid, r_wBot, r_dTop, r_dMid, r_dBot;
   logic signed [ACC_W-1:0] r_cTop, r_cMid, r_cBot, r_lrMid;
   logic signed [ACC_W-1:0] w_sumA, w_sumB, r_sumA, r_sumB, w_absA, w_absB, w_res;
   logic w_busy, w_advance, w_inFire, w_frameEnd;
   logic [PIX_W-1:0] w_tl, w_tc, w_tr, w_ml, w_mc, w_mr, w_bl, w_bc, w_br;

   assign {w_tl, w_tc, w_tr} = win_top;
   assign {w_ml, w_mc, w_mr} = win_mid;
   assign {w_bl, w_bc, w_br} = win_bot;

   assign w_busy     = (r_state == ST_RUN);
   assign w_advance  = ~r_outValid | out_ready;
   assign in_ready   = w_busy & w_advance & ~r_inDone;
   assign w_inFire   = in_valid & in_ready;
   assign w_frameEnd = r_outValid & out_ready & r_outLast;

   assign busy      = w_busy;
   assign done      = r_done;
   assign pix_out   = r_pix;
   assign out_col   = r_outCol;
   assign out_row   = r_outRow;
   assign out_last  = r_outLast;
   assign out_valid = r_outValid;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: if (start) w_stateNext = ST_RUN;
         ST_RUN:  if (w_frameEnd) w_stateNext = ST_IDLE;
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // Frame control, input raster counter and stage valid bits; reset flushes the pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done   <= 1'b0;
         r_modeQ  <= MODE_BLUR;
         r_inCol  <= '0;
         r_inRow  <= '0;
         r_inDone <= 1'b0;
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
      end else begin
         r_done <= w_frameEnd;
         if (w_advance) begin
            r_v1 <= w_inFire;
            r_v2 <= r_v1;
         end
         if (r_state == ST_IDLE && start) begin
            r_modeQ  <= conv_mode_e'(mode);
            r_inCol  <= '0;
            r_inRow  <= '0;
            r_inDone <= 1'b0;
         end else if (w_inFire) begin
            if (r_inCol == LAST_COL) begin
               r_inCol <= '0;
               if (r_inRow == LAST_ROW) r_inDone <= 1'b1;
               else                     r_inRow  <= r_inRow + 8'd1;
            end else begin
               r_inCol <= r_inCol + 8'd1;
            end
         end
      end
   end

   // Datapath stages carry no reset; the valid bits above qualify them.
   always_ff @(posedge clk) begin
      if (w_advance) begin
         if (w_inFire) begin
            r_wTop  <= ext(w_tl) + (ext(w_tc) <<< 1) + ext(w_tr);
            r_wMid  <= ext(w_ml) + (ext(w_mc) <<< 1) + ext(w_mr);
            r_wBot  <= ext(w_bl) + (ext(w_bc) <<< 1) + ext(w_br);
            r_dTop  <= ext(w_tr) - ext(w_tl);
            r_dMid  <= ext(w_mr) - ext(w_ml);
            r_dBot  <= ext(w_br) - ext(w_bl);
            r_cTop  <= ext(w_tc);
            r_cMid  <= ext(w_mc);
            r_cBot  <= ext(w_bc);
            r_lrMid <= ext(w_ml) + ext(w_mr);
            r_col1  <= r_inCol;
            r_row1  <= r_inRow;
         end
         r_sumA <= w_sumA;
         r_sumB <= w_sumB;
         r_col2 <= r_col1;
         r_row2 <= r_row1;
      end
   end

   conv3x3_kernel u_kernel (
      .i_mode  (r_modeQ),
      .i_wTop  (r_wTop),
      .i_wMid  (r_wMid),
      .i_wBot  (r_wBot),
      .i_dTop  (r_dTop),
      .i_dMid  (r_dMid),
      .i_dBot  (r_dBot),
      .i_cTop  (r_cTop),
      .i_cMid  (r_cMid),
      .i_cBot  (r_cBot),
      .i_lrMid (r_lrMid),
      .o_sumA  (w_sumA),
      .o_sumB  (w_sumB)
   );

   always_comb begin
      w_absA = r_sumA[ACC_W-1] ? -r_sumA : r_sumA;
      w_absB = r_sumB[ACC_W-1] ? -r_sumB : r_sumB;
      w_res  = r_sumA;
      case (r_modeQ)
         MODE_BLUR: w_res = r_sumA >>> 4;
         MODE_EDGE: w_res = w_absA + w_absB;
         default:   w_res = r_sumA;
      endcase
      if (w_res < 0)            w_pix = '0;
      else if (w_res > PIX_MAX) w_pix = '1;
      else                      w_pix = w_res[PIX_W-1:0];
`ifdef CONV_BORDER_ZERO_EN
      if (r_modeQ != MODE_PASS &&
          (r_col2 == 8'd0 || r_col2 == LAST_COL || r_row2 == 8'd0 || r_row2 == LAST_ROW))
         w_pix = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_pix      <= '0;
         r_outCol   <= '0;
         r_outRow   <= '0;
         r_outLast  <= 1'b0;
      end else if (w_advance) begin
         r_outValid <= r_v2;
         if (r_v2) begin
            r_pix     <= w_pix;
            r_outCol  <= r_col2;
            r_outRow  <= r_row2;
            r_outLast <= (r_col2 == LAST_COL) && (r_row2 == LAST_ROW);
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench for conv3x3_engine on a 4x2 frame: driver pushes hand-computed
// expectations at each input handshake, a monitor pops them at each output handshake.
module tb_conv3x3_engine;

   localparam int PW = 12;
   localparam int IW = 4;
   localparam int IH = 2;

   logic          clk = 1'b0;
   logic          rst, start, busy, done, in_valid, in_ready;
   logic          out_last, out_valid, out_ready;
   logic [1:0]    mode;
   logic [3*PW-1:0] win_top, win_mid, win_bot;
   logic [PW-1:0] pix_out;
   logic [7:0]    out_col, out_row;

   always #5 clk = ~clk;

   conv3x3_engine #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
      .win_top(win_top), .win_mid(win_mid), .win_bot(win_bot),
      .in_valid(in_valid), .in_ready(in_ready), .pix_out(pix_out),
      .out_col(out_col), .out_row(out_row), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   typedef struct {
      logic [11:0] pix;
      logic [7:0]  col;
      logic [7:0]  row;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   logic [35:0] vTop[32], vMid[32], vBot[32];
   logic [11:0] vExp[32];
   int          nChecks = 0, nFails = 0, framesDone = 0;
   bit          randReady = 1'b0, expectDone = 1'b0;

   function automatic logic [35:0] row3(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
      return {l, c, r};
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic setVec(input int i, input logic [35:0] t, input logic [35:0] m,
                         input logic [35:0] b, input logic [11:0] e);
      vTop[i] = t; vMid[i] = m; vBot[i] = b; vExp[i] = e;
   endtask

   task automatic applyStimulus(input int idx, input int pos);
      int   tries = 0;
      bit   ok = 1'b0;
      exp_t e;
      @(negedge clk);
      win_top = vTop[idx]; win_mid = vMid[idx]; win_bot = vBot[idx];
      in_valid = 1'b1;
      while (!ok && tries < 100) begin
         #1;
         if (in_ready) begin
            e.pix = vExp[idx]; e.col = 8'(pos % IW); e.row = 8'(pos / IW);
            e.last = (pos == IW*IH-1);
            sb.push_back(e);
            @(posedge clk);
            ok = 1'b1;
         end else begin
            tries++;
            @(negedge clk);
         end
      end
      #1 in_valid = 1'b0;
      if (!ok) checkOutput("input handshake timeout", 0, 1);
   endtask

   task automatic startFrame(input logic [1:0] m);
      @(negedge clk);
      mode = m; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic waitFrame(input int base);
      int n = 0;
      while (framesDone == base && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frame done count", framesDone - base, 1);
      checkOutput("busy after frame", busy, 0);
      checkOutput("scoreboard drained", sb.size(), 0);
   endtask

   task automatic runFrame(input logic [1:0] m, input int base, input bit rr);
      int cnt;
      randReady = rr;
      cnt = framesDone;
      startFrame(m);
      for (int k = 0; k < IW*IH; k++) applyStimulus(base + k, k);
      waitFrame(cnt);
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            expectDone = 1'b0;
            continue;
         end
         if (expectDone || done) begin
            checkOutput("done pulse", done, expectDone);
            if (done) framesDone++;
         end
         expectDone = 1'b0;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected output", 1, 0);
            end else begin
               e = sb.pop_front();
               checkOutput("pix_out", pix_out, e.pix);
               checkOutput("out_row/out_col", {out_row, out_col}, {e.row, e.col});
               checkOutput("out_last", out_last, e.last);
               if (e.last) expectDone = 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] stalled");
   end

   initial begin
      int cnt;
      rst = 1'b1; start = 1'b0; mode = 2'd0; in_valid = 1'b0;
      win_top = '0; win_mid = '0; win_bot = '0;

      // BLUR
      setVec(0,  row3(12'h100,12'h100,12'h100), row3(12'h100,12'h100,12'h100), row3(12'h100,12'h100,12'h100), 12'h100);
      setVec(1,  row3(12'hFFF,12'hFFF,12'hFFF), row3(12'hFFF,12'hFFF,12'hFFF), row3(12'hFFF,12'hFFF,12'hFFF), 12'hFFF);
      setVec(2,  row3(0,0,0), row3(0,12'h010,0), row3(0,0,0), 12'h004);
      setVec(3,  row3(0,0,0), row3(0,0,0), row3(0,0,0), 12'h000);
      setVec(4,  row3(12'h00F,0,0), row3(0,0,0), row3(0,0,0), 12'h000);
      setVec(5,  row3(12'h010,0,0), row3(12'h010,0,0), row3(12'h010,0,0), 12'h004);
      setVec(6,  row3(0,0,0), row3(12'h010,12'h010,12'h010), row3(0,0,0), 12'h008);
      setVec(7,  row3(12'h0FF,12'h0FF,12'h0FF), row3(0,0,0), row3(0,0,0), 12'h03F);
      // SHARPEN
      setVec(8,  row3(0,0,0), row3(0,12'hFFF,0), row3(0,0,0), 12'hFFF);
      setVec(9,  row3(12'hFFF,12'hFFF,12'hFFF), row3(12'hFFF,0,12'hFFF), row3(12'hFFF,12'hFFF,12'hFFF), 12'h000);
      setVec(10, row3(12'h100,12'h100,12'h100), row3(12'h100,12'h100,12'h100), row3(12'h100,12'h100,12'h100), 12'h100);
      setVec(11, row3(0,0,0), row3(0,12'h100,0), row3(0,0,0), 12'h500);
      setVec(12, row3(12'hFFF,0,12'hFFF), row3(0,12'h010,0), row3(12'hFFF,0,12'hFFF), 12'h050);
      setVec(13, row3(0,12'h010,0), row3(0,0,0), row3(0,0,0), 12'h000);
      setVec(14, row3(0,0,0), row3(12'h100,12'h300,0), row3(0,0,0), 12'hE00);
      setVec(15, row3(0,0,0), row3(0,12'h200,12'h050), row3(0,12'h030,0), 12'h980);
      // EDGE
      setVec(16, row3(0,0,12'hFFF), row3(0,0,12'hFFF), row3(0,0,12'hFFF), 12'hFFF);
      setVec(17, row3(12'h5A5,12'h5A5,12'h5A5), row3(12'h5A5,12'h5A5,12'h5A5), row3(12'h5A5,12'h5A5,12'h5A5), 12'h000);
      setVec(18, row3(0,0,12'h001), row3(0,0,12'h001), row3(0,0,12'h001), 12'h004);
      setVec(19, row3(0,0,0), row3(0,0,0), row3(12'h002,12'h002,12'h002), 12'h008);
      setVec(20, row3(12'h010,0,0), row3(0,0,0), row3(0,0,0), 12'h020);
      setVec(21, row3(0,0,0), row3(0,12'hFFF,0), row3(0,0,0), 12'h000);
      setVec(22, row3(0,0,0), row3(0,0,12'h100), row3(0,0,0), 12'h200);
      setVec(23, row3(0,0,12'h100), row3(0,0,0), row3(0,0,0), 12'h200);
      // PASS: centre of middle row is 1..8, everything else is noise
      for (int k = 0; k < 8; k++)
         setVec(24 + k, row3(12'(k*3), 12'hABC, 12'h123), row3(12'hFFF, 12'(k+1), 12'h777),
                row3(12'h0F0, 12'h00F, 12'hF00), 12'(k+1));

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset pix_out", pix_out, 0);
      checkOutput("reset coords", {out_row, out_col}, 0);
      checkOutput("reset out_last", out_last, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1 checkOutput("idle in_ready", in_ready, 0);

      $display("[TB] BLUR frame with latency check");
      randReady = 1'b0;
      cnt = framesDone;
      startFrame(2'd0);
      checkOutput("busy after start", busy, 1);
      applyStimulus(0, 0);
      checkOutput("latency edge1 out_valid", out_valid, 0);
      @(posedge clk);
      #1 checkOutput("latency edge2 out_valid", out_valid, 0);
      @(posedge clk);
      #1 checkOutput("latency edge3 out_valid", out_valid, 1);
      checkOutput("latency edge3 pix_out", pix_out, 12'h100);
      for (int k = 1; k < 8; k++) applyStimulus(k, k);
      checkOutput("in_ready after last window", in_ready, 0);
      waitFrame(cnt);

      $display("[TB] SHARPEN and EDGE frames with backpressure");
      runFrame(2'd1, 8, 1'b1);
      runFrame(2'd2, 16, 1'b1);

      $display("[TB] PASS frame with ignored mid-frame start");
      randReady = 1'b1;
      cnt = framesDone;
      startFrame(2'd3);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(24 + k, k);
         if (k == 3) startFrame(2'd0);
      end
      waitFrame(cnt);

      $display("[TB] reset mid-frame");
      cnt = framesDone;
      startFrame(2'd3);
      for (int k = 0; k < 5; k++) applyStimulus(24 + k, k);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      checkOutput("rst out_valid", out_valid, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst done", done, 0);
      repeat (10) @(negedge clk);
      checkOutput("no done after rst", framesDone, cnt);

      $display("[TB] clean PASS frame after reset");
      runFrame(2'd3, 24, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
